// File: rtl/buzzer_gen.sv
// Multi-channel buzzer pattern generator: CONST, BLINK and BURST modes
// with optional square-wave tone on the active phase.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   enable[i]          - level-sensitive run request for channel i
//   mode[2i+:2]        - 0 OFF, 1 CONST, 2 BLINK, 3 BURST
//   duration_on/off    - active/silent phase length in cycles (0 acts as 1)
//   burst_count[8i+:8] - active phases per burst (0 acts as 1)
//   tone_half_period   - tone half period in cycles, 0 = steady level
//   busy[i]            - channel not idle
//   done[i]            - one-cycle pulse after a burst completes
//   BUZZER_OUT[i]      - buzzer drive, polarity set by INVERSE_MODE
module buzzer_gen #(
  parameter int CHANNELS     = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int INVERSE_MODE = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           enable,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CNT_WIDTH*CHANNELS-1:0] duration_on,
  input  logic [CNT_WIDTH*CHANNELS-1:0] duration_off,
  input  logic [8*CHANNELS-1:0]         burst_count,
  input  logic [CNT_WIDTH*CHANNELS-1:0] tone_half_period,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           done,
  output logic [CHANNELS-1:0]           BUZZER_OUT
);

  localparam int   W   = CNT_WIDTH;
  localparam logic INV = (INVERSE_MODE != 0);

  typedef enum logic [2:0] {
    IDLE,
    HOLD_ON,
    HOLD_OFF,
    CONST_ON,
    DONE
  } state_t;

  // Terminal count for a phase; a zero length behaves as one cycle,
  // so the compare value never wraps.
  function automatic logic [W-1:0] lim_w(input logic [W-1:0] d);
    return (d == '0) ? '0 : d - W'(1);
  endfunction

  function automatic logic [7:0] lim_b(input logic [7:0] d);
    return (d == 8'd0) ? 8'd0 : d - 8'd1;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t     st;
    logic [W-1:0] cnt;
    logic [W-1:0] tcnt;
    logic [W-1:0] on_lim;
    logic [W-1:0] off_lim;
    logic [W-1:0] t_lim;
    logic         t_en;
    logic [7:0]   bcnt;
    logic [7:0]   b_lim;
    logic         burst;
    logic         tph;
    logic         busy_r;
    logic         done_r;
    logic         pend;
    logic         out_r;

    logic [W-1:0] d_on;
    logic [W-1:0] d_off;
    logic [W-1:0] d_tone;
    logic [1:0]   md;
    logic [7:0]   bc;
    logic         t_wrap;

    assign d_on   = duration_on[i*W +: W];
    assign d_off  = duration_off[i*W +: W];
    assign d_tone = tone_half_period[i*W +: W];
    assign md     = mode[2*i +: 2];
    assign bc     = burst_count[8*i +: 8];
    assign t_wrap = t_en && (tcnt == t_lim);

    // Output is driven from the current state, so it trails the state
    // register by one edge; dropping enable bypasses that lag.
    always_ff @(posedge clk) begin
      if (reset) begin
        st      <= IDLE;
        cnt     <= '0;
        tcnt    <= '0;
        on_lim  <= '0;
        off_lim <= '0;
        t_lim   <= '0;
        t_en    <= 1'b0;
        bcnt    <= 8'd0;
        b_lim   <= 8'd0;
        burst   <= 1'b0;
        tph     <= 1'b1;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
        pend    <= 1'b0;
        out_r   <= INV;
      end else begin
        done_r <= 1'b0;
        pend   <= 1'b0;
        if (st == IDLE) begin
          out_r <= INV;
          if (enable[i] && md != 2'd0) begin
            on_lim  <= lim_w(d_on);
            off_lim <= lim_w(d_off);
            t_lim   <= lim_w(d_tone);
            t_en    <= (d_tone != '0);
            b_lim   <= lim_b(bc);
            burst   <= (md == 2'd3);
            cnt     <= '0;
            tcnt    <= '0;
            bcnt    <= 8'd0;
            tph     <= 1'b1;
            busy_r  <= 1'b1;
            st      <= (md == 2'd1) ? CONST_ON : HOLD_ON;
          end
        end else if (!enable[i]) begin
          st     <= IDLE;
          busy_r <= 1'b0;
          out_r  <= INV;
          cnt    <= '0;
          tcnt   <= '0;
          bcnt   <= 8'd0;
          tph    <= 1'b1;
        end else begin
          unique case (st)
            HOLD_ON: begin
              out_r <= tph ^ INV;
              if (t_wrap) begin
                tcnt <= '0;
                tph  <= ~tph;
              end else if (t_en) begin
                tcnt <= tcnt + W'(1);
              end
              if (cnt == on_lim) begin
                cnt <= '0;
                if (burst && bcnt == b_lim) begin
                  st   <= DONE;
                  pend <= 1'b1;
                end else begin
                  if (burst) bcnt <= bcnt + 8'd1;
                  st <= HOLD_OFF;
                end
              end else begin
                cnt <= cnt + W'(1);
              end
            end
            HOLD_OFF: begin
              out_r <= INV;
              if (cnt == off_lim) begin
                cnt  <= '0;
                tcnt <= '0;
                tph  <= 1'b1;
                st   <= HOLD_ON;
              end else begin
                cnt <= cnt + W'(1);
              end
            end
            CONST_ON: begin
              out_r <= tph ^ INV;
              if (t_wrap) begin
                tcnt <= '0;
                tph  <= ~tph;
              end else if (t_en) begin
                tcnt <= tcnt + W'(1);
              end
            end
            DONE: begin
              out_r  <= INV;
              done_r <= pend;
            end
            default: begin
              st     <= IDLE;
              busy_r <= 1'b0;
              out_r  <= INV;
            end
          endcase
        end
      end
    end

    assign busy[i]       = busy_r;
    assign done[i]       = done_r;
    assign BUZZER_OUT[i] = out_r;
  end

endmodule

// File: tb/tb_buzzer_gen.sv
// Directed self-checking bench for buzzer_gen.
// Two channels, 32-bit counters, active-low output.
module tb_buzzer_gen;

  localparam int C = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   enable;
  logic [2*C-1:0] mode;
  logic [W*C-1:0] duration_on;
  logic [W*C-1:0] duration_off;
  logic [8*C-1:0] burst_count;
  logic [W*C-1:0] tone_half_period;
  logic [C-1:0]   busy;
  logic [C-1:0]   done;
  logic [C-1:0]   BUZZER_OUT;

  int passed = 0;
  int total  = 0;

  buzzer_gen #(
    .CHANNELS(C),
    .CNT_WIDTH(W),
    .INVERSE_MODE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .duration_on(duration_on),
    .duration_off(duration_off),
    .burst_count(burst_count),
    .tone_half_period(tone_half_period),
    .busy(busy),
    .done(done),
    .BUZZER_OUT(BUZZER_OUT)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [1:0] m, input int on,
                     input int off, input int bc, input int tone);
    mode[2*ch +: 2]             = m;
    duration_on[ch*W +: W]      = on;
    duration_off[ch*W +: W]     = off;
    burst_count[8*ch +: 8]      = 8'(bc);
    tone_half_period[ch*W +: W] = tone;
  endtask

  task automatic idle_all;
    enable = '0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = '0;
    mode = '0;
    duration_on = '0;
    duration_off = '0;
    burst_count = '0;
    tone_half_period = '0;
    tick();
    total++;
    if (BUZZER_OUT !== 2'b11)
      $display("FAIL reset_out got %b want 11", BUZZER_OUT);
    else passed++;
    total++;
    if (busy !== 2'b00)
      $display("FAIL reset_busy got %b want 00", busy);
    else passed++;
    total++;
    if (done !== 2'b00)
      $display("FAIL reset_done got %b want 00", done);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  // Blink 3 on / 2 off; config changes mid-run must be ignored,
  // then take effect after enable drops and rises again.
  task automatic test_blink_and_freeze;
    logic [4:0] pat;
    logic exp;
    pat = 5'b11000;
    cfg(0, 2'd2, 3, 2, 0, 0);
    enable[0] = 1'b1;
    tick();
    total++;
    if (busy[0] !== 1'b1 || BUZZER_OUT[0] !== 1'b1)
      $display("FAIL blink_start busy=%b out=%b want busy=1 out=1",
               busy[0], BUZZER_OUT[0]);
    else passed++;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp = pat[k % 5];
      total++;
      if (BUZZER_OUT[0] !== exp)
        $display("FAIL blink_k%0d got %b want %b", k, BUZZER_OUT[0], exp);
      else passed++;
      if (k == 4) cfg(0, 2'd1, 7, 9, 0, 0);
    end
    enable[0] = 1'b0;
    tick();
    total++;
    if (BUZZER_OUT[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL blink_stop out=%b busy=%b want 1 0",
               BUZZER_OUT[0], busy[0]);
    else passed++;
    enable[0] = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (BUZZER_OUT[0] !== 1'b0)
        $display("FAIL reconfig_const_k%0d got %b want 0", k, BUZZER_OUT[0]);
      else passed++;
    end
    idle_all();
  endtask

  task automatic test_burst;
    logic eo;
    logic ed;
    cfg(1, 2'd3, 2, 2, 3, 0);
    enable[1] = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      eo = !((k <= 10) && (((k - 1) % 4) < 2));
      ed = (k == 11);
      total++;
      if (BUZZER_OUT[1] !== eo || done[1] !== ed || busy[1] !== 1'b1)
        $display("FAIL burst_k%0d out=%b done=%b busy=%b want %b %b 1",
                 k, BUZZER_OUT[1], done[1], busy[1], eo, ed);
      else passed++;
    end
    enable[1] = 1'b0;
    tick();
    total++;
    if (busy[1] !== 1'b0 || BUZZER_OUT[1] !== 1'b1 || done[1] !== 1'b0)
      $display("FAIL burst_release busy=%b out=%b done=%b want 0 1 0",
               busy[1], BUZZER_OUT[1], done[1]);
    else passed++;
    idle_all();
  endtask

  task automatic test_const_tone;
    logic eo;
    cfg(0, 2'd1, 0, 0, 0, 2);
    enable[0] = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      eo = (((k - 1) / 2) % 2) != 0;
      total++;
      if (BUZZER_OUT[0] !== eo)
        $display("FAIL tone_k%0d got %b want %b", k, BUZZER_OUT[0], eo);
      else passed++;
    end
    enable[0] = 1'b0;
    tick();
    total++;
    if (BUZZER_OUT[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL tone_stop out=%b busy=%b want 1 0",
               BUZZER_OUT[0], busy[0]);
    else passed++;
    idle_all();
  endtask

  // Zero lengths on ch0 alongside a steady CONST on ch1.
  task automatic test_zero_dur_parallel;
    logic [1:0] eo;
    cfg(0, 2'd2, 0, 0, 0, 0);
    cfg(1, 2'd1, 0, 0, 0, 0);
    enable = 2'b11;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      eo = {1'b0, (k % 2) == 0};
      total++;
      if (BUZZER_OUT !== eo)
        $display("FAIL zero_dur_k%0d got %b want %b", k, BUZZER_OUT, eo);
      else passed++;
    end
    idle_all();
  endtask

  task automatic test_reset_mid_burst;
    cfg(0, 2'd3, 2, 2, 3, 0);
    cfg(1, 2'd3, 3, 1, 2, 0);
    enable = 2'b11;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (BUZZER_OUT !== 2'b11 || busy !== 2'b00 || done !== 2'b00)
      $display("FAIL midreset out=%b busy=%b done=%b want 11 00 00",
               BUZZER_OUT, busy, done);
    else passed++;
    reset = 1'b0;
    enable = 2'b00;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (done !== 2'b00 || busy !== 2'b00 || BUZZER_OUT !== 2'b11)
        $display("FAIL midreset_after_k%0d done=%b busy=%b out=%b",
                 k, done, busy, BUZZER_OUT);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = '0;
    test_reset();
    test_blink_and_freeze();
    test_burst();
    test_const_tone();
    test_zero_dur_parallel();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/buzzer_gen.md
BUZZER_GEN -- requirements
Module: buzzer_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent buzzer channels (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of all duration/period counters.
REQ-003 SHALL have parameter INVERSE_MODE, default 1, 1 = BUZZER_OUT active-low, 0 = active-high.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  CHANNELS  per-channel run request, level sensitive.
REQ-007 SHALL have port mode  input  2*CHANNELS  per channel: 0 OFF, 1 CONST, 2 BLINK, 3 BURST.
REQ-008 SHALL have ports duration_on, duration_off  input  CNT_WIDTH*CHANNELS  active and silent phase lengths in clk cycles.
REQ-009 SHALL have port burst_count  input  8*CHANNELS  number of active phases in BURST mode.
REQ-010 SHALL have port tone_half_period  input  CNT_WIDTH*CHANNELS  tone half period in cycles; 0 = no tone (steady level).
REQ-011 SHALL have port busy  output  CHANNELS  channel not in IDLE.
REQ-012 SHALL have port done  output  CHANNELS  one-cycle pulse at BURST completion.
REQ-013 SHALL have port BUZZER_OUT  output  CHANNELS  physical buzzer drive.
REQ-014 Channel i SHALL use bit slice [i] / field [i*W +: W] of every packed port.

Function
REQ-015 Each channel SHALL run an independent FSM: IDLE, HOLD_ON, HOLD_OFF, CONST_ON, DONE.
REQ-016 IDLE with enable=1 and mode!=0 SHALL latch mode, durations, burst_count, tone_half_period, then go to CONST_ON (mode 1) or HOLD_ON (modes 2,3); mode 0 stays IDLE.
REQ-017 Latched config SHALL be held until return to IDLE; input changes mid-operation ignored.
REQ-018 HOLD_ON SHALL last max(duration_on,1) cycles, then HOLD_OFF; HOLD_OFF SHALL last max(duration_off,1) cycles, then HOLD_ON.
REQ-019 BURST SHALL count completed HOLD_ON phases; burst_count 0 treated as 1; after the last HOLD_ON go to DONE directly, skipping HOLD_OFF.
REQ-020 Entry to DONE SHALL assert done for exactly one cycle; DONE SHALL hold output inactive until enable=0, then IDLE (no retrigger while enable held).
REQ-021 enable=0 in any non-IDLE state SHALL force IDLE on next edge; output inactive that same edge.
REQ-022 Internal "active" = 1 in HOLD_ON and CONST_ON, else 0.
REQ-023 With latched tone_half_period=P>0, active output SHALL toggle every P cycles, starting at active level on each HOLD_ON/CONST_ON entry; tone counter reset on each entry.
REQ-024 BUZZER_OUT[i] SHALL equal (active AND tone_phase) XOR INVERSE_MODE, registered.
REQ-025 Latency: enable sampled high at edge t SHALL give active BUZZER_OUT from edge t+1.
REQ-026 busy SHALL be 1 in every state except IDLE, registered with state.
REQ-027 Counters SHALL saturate-free count up and compare to (latched value - 1); no wrap for any CNT_WIDTH value, including all-ones.
REQ-028 Channels SHALL not interact; simultaneous events on different channels handled independently.

Reset
REQ-029 reset=1 at an edge SHALL force all channels to IDLE, clear counters, busy=0, done=0, BUZZER_OUT={CHANNELS{INVERSE_MODE[0]}}.
REQ-030 reset SHALL take priority over enable at the same edge, including mid-burst.

Verification
REQ-031 INVERSE_MODE=1, ch0 BLINK on=3 off=2 tone=0, enable held -> BUZZER_OUT[0] pattern 0,0,0,1,1 repeating from edge t+1.
REQ-032 ch1 BURST on=2 off=2 count=3 -> 3 low pulses of 2 cycles, done[1] pulse one cycle after 3rd pulse ends, then BUZZER_OUT=1, busy=1 until enable=0.
REQ-033 CONST tone=2 -> active output toggles every 2 cycles while enable=1; enable=0 -> inactive next edge, busy=0.
REQ-034 Change mode/durations during BLINK -> pattern unchanged until enable drops and rises again.
REQ-035 reset pulse mid-BURST on both channels -> all outputs at reset values next edge; no done pulse.
REQ-036 duration_on=0, duration_off=0, BLINK -> 1-cycle on/1-cycle off alternation.
